monkey_contact_detector: RTL and testbench

Per-frame contact classifier that sits directly upstream of the monkey movement/collision block. During each frame it accumulates pixel-level overlaps between the monkey sprite and the rope, block and enemy draw requests. At each startOfFrame it publishes stable onRope/onBlock/collision/objectHit/HitEdgeCode flags that stay constant for the whole next frame.

---
 rtl/monkey_contact_detector.sv | 127 ++++++++++++
 tb/tb_monkey_contact_detector.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/monkey_contact_detector.sv
// Per-frame contact classifier: accumulates monkey overlaps with rope/block/enemy
// during a frame and publishes stable contact flags at each startOfFrame.
module monkey_contact_detector #(
  parameter int OBJECT_WIDTH    = 32,
  parameter int OBJECT_HEIGHT   = 32,
  parameter int EDGE_MARGIN     = 4,
  parameter int FOOT_ROWS       = 3,
  parameter int ROPE_MIN_PIXELS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        monkeyDR,
  input  logic [10:0] monkeyOffsetX,
  input  logic [10:0] monkeyOffsetY,
  input  logic        ropeDR,
  input  logic        blockDR,
  input  logic        enemyDR,
  output logic        onRope,
  output logic        onBlock,
  output logic        collision,
  output logic        objectHit,
  output logic [3:0]  HitEdgeCode,
  output logic        hitPulse,
  output logic        frameValid
);

  localparam logic [10:0] FOOT_Y   = 11'(OBJECT_HEIGHT - FOOT_ROWS);
  localparam logic [10:0] MARGIN   = 11'(EDGE_MARGIN);
  localparam logic [10:0] BOTTOM_Y = 11'(OBJECT_HEIGHT - EDGE_MARGIN);
  localparam logic [10:0] RIGHT_X  = 11'(OBJECT_WIDTH - EDGE_MARGIN);
  localparam logic [7:0]  ROPE_MIN = 8'(ROPE_MIN_PIXELS);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t     state, nextState;
  logic       latchEn;

  logic       ropeHit, footHit, anyHit, enemyHit;
  logic [3:0] edgeHit;

  logic [7:0] ropeCnt;
  logic       footAcc, anyAcc, enemyAcc;
  logic [3:0] edgeAcc;

  function automatic logic [7:0] satInc(input logic [7:0] cnt, input logic inc);
    if (inc && cnt != 8'hFF) return cnt + 8'd1;
    return cnt;
  endfunction

  // Stage p0: per-pixel overlap terms
  always_comb begin
    ropeHit    = monkeyDR & ropeDR;
    footHit    = monkeyDR & blockDR & (monkeyOffsetY >= FOOT_Y);
    anyHit     = monkeyDR & (ropeDR | blockDR | enemyDR);
    enemyHit   = monkeyDR & enemyDR;
    edgeHit[0] = anyHit & (monkeyOffsetY < MARGIN);
    edgeHit[1] = anyHit & (monkeyOffsetX >= RIGHT_X);
    edgeHit[2] = anyHit & (monkeyOffsetY >= BOTTOM_Y);
    edgeHit[3] = anyHit & (monkeyOffsetX < MARGIN);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    latchEn   = 1'b0;
    case (state)
      IDLE:       if (startOfFrame) nextState = ARMED;
      ARMED, RUN: if (startOfFrame) begin
                    latchEn   = 1'b1;
                    nextState = RUN;
                  end
      default:    nextState = IDLE;
    endcase
  end

  // Stage p1: frame accumulators; a pixel coinciding with startOfFrame seeds the new frame
  always_ff @(posedge clk) begin
    if (reset) begin
      ropeCnt  <= '0;
      footAcc  <= 1'b0;
      anyAcc   <= 1'b0;
      enemyAcc <= 1'b0;
      edgeAcc  <= '0;
    end else if (startOfFrame) begin
      ropeCnt  <= {7'd0, ropeHit};
      footAcc  <= footHit;
      anyAcc   <= anyHit;
      enemyAcc <= enemyHit;
      edgeAcc  <= edgeHit;
    end else begin
      ropeCnt  <= satInc(ropeCnt, ropeHit);
      footAcc  <= footAcc | footHit;
      anyAcc   <= anyAcc | anyHit;
      enemyAcc <= enemyAcc | enemyHit;
      edgeAcc  <= edgeAcc | edgeHit;
    end
  end

  // Stage p2: published flags, held for the whole following frame
  always_ff @(posedge clk) begin
    if (reset) begin
      onRope      <= 1'b0;
      onBlock     <= 1'b0;
      collision   <= 1'b0;
      objectHit   <= 1'b0;
      HitEdgeCode <= '0;
      hitPulse    <= 1'b0;
    end else if (latchEn) begin
      onRope      <= (ropeCnt >= ROPE_MIN);
      onBlock     <= footAcc;
      collision   <= anyAcc;
      objectHit   <= enemyAcc;
      HitEdgeCode <= edgeAcc;
      hitPulse    <= enemyAcc & ~objectHit;
    end else begin
      hitPulse    <= 1'b0;
    end
  end

  assign frameValid = (state == RUN);

endmodule

// File: tb/tb_monkey_contact_detector.sv
// Directed bench for monkey_contact_detector: frame latching, rope threshold and
// saturation, foot/edge zones, hit pulse and mid-frame reset.
module tb_monkey_contact_detector;

  logic        clk = 1'b0;
  logic        reset, startOfFrame, monkeyDR, ropeDR, blockDR, enemyDR;
  logic [10:0] monkeyOffsetX, monkeyOffsetY;
  logic        onRope, onBlock, collision, objectHit, hitPulse, frameValid;
  logic [3:0]  HitEdgeCode;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  monkey_contact_detector dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .monkeyDR(monkeyDR), .monkeyOffsetX(monkeyOffsetX), .monkeyOffsetY(monkeyOffsetY),
    .ropeDR(ropeDR), .blockDR(blockDR), .enemyDR(enemyDR),
    .onRope(onRope), .onBlock(onBlock), .collision(collision), .objectHit(objectHit),
    .HitEdgeCode(HitEdgeCode), .hitPulse(hitPulse), .frameValid(frameValid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearIn();
    startOfFrame = 1'b0; monkeyDR = 1'b0; ropeDR = 1'b0; blockDR = 1'b0; enemyDR = 1'b0;
    monkeyOffsetX = 11'd0; monkeyOffsetY = 11'd0;
  endtask

  task automatic pixels(input int n, input int x, input int y,
                        input logic r, input logic b, input logic e);
    monkeyDR = 1'b1; ropeDR = r; blockDR = b; enemyDR = e;
    monkeyOffsetX = 11'(x); monkeyOffsetY = 11'(y);
    repeat (n) tick();
    clearIn();
  endtask

  task automatic sofPulse();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  initial begin
    clearIn();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_onRope", {7'd0, onRope}, 8'd0);
    chk("rst_collision", {7'd0, collision}, 8'd0);
    chk("rst_edge", {4'd0, HitEdgeCode}, 8'd0);
    chk("rst_frameValid", {7'd0, frameValid}, 8'd0);
    chk("rst_hitPulse", {7'd0, hitPulse}, 8'd0);

    // Empty frames: first pulse only arms, second publishes
    sofPulse();
    chk("arm_frameValid", {7'd0, frameValid}, 8'd0);
    tick(); tick();
    sofPulse();
    chk("empty_frameValid", {7'd0, frameValid}, 8'd1);
    chk("empty_flags", {4'd0, onRope, onBlock, collision, objectHit}, 8'd0);
    chk("empty_edge", {4'd0, HitEdgeCode}, 8'd0);

    // Rope threshold: 5 pixels below, 6 pixels at ROPE_MIN_PIXELS
    pixels(5, 10, 10, 1'b1, 1'b0, 1'b0);
    sofPulse();
    chk("rope5_onRope", {7'd0, onRope}, 8'd0);
    chk("rope5_collision", {7'd0, collision}, 8'd1);
    pixels(6, 10, 10, 1'b1, 1'b0, 1'b0);
    sofPulse();
    chk("rope6_onRope", {7'd0, onRope}, 8'd1);
    chk("rope6_collision", {7'd0, collision}, 8'd1);

    // Block at foot row, bottom-left corner zone
    pixels(1, 0, 30, 1'b0, 1'b1, 1'b0);
    sofPulse();
    chk("foot_onBlock", {7'd0, onBlock}, 8'd1);
    chk("foot_edge", {4'd0, HitEdgeCode}, 8'b0000_1100);
    chk("foot_onRope", {7'd0, onRope}, 8'd0);
    // Block in sprite interior
    pixels(1, 10, 10, 1'b0, 1'b1, 1'b0);
    sofPulse();
    chk("mid_onBlock", {7'd0, onBlock}, 8'd0);
    chk("mid_edge", {4'd0, HitEdgeCode}, 8'd0);
    chk("mid_collision", {7'd0, collision}, 8'd1);

    // Enemy rising edge gives a single pulse
    pixels(1, 10, 10, 1'b0, 1'b0, 1'b1);
    sofPulse();
    chk("enemy1_objectHit", {7'd0, objectHit}, 8'd1);
    chk("enemy1_hitPulse", {7'd0, hitPulse}, 8'd1);
    tick();
    chk("enemy1_pulseEnd", {7'd0, hitPulse}, 8'd0);
    chk("enemy1_hold", {7'd0, objectHit}, 8'd1);
    // Enemy again at top-right corner: no new pulse
    pixels(1, 31, 0, 1'b0, 1'b0, 1'b1);
    sofPulse();
    chk("enemy2_objectHit", {7'd0, objectHit}, 8'd1);
    chk("enemy2_hitPulse", {7'd0, hitPulse}, 8'd0);
    chk("enemy2_edge", {4'd0, HitEdgeCode}, 8'b0000_0011);

    // Rope saturation, then a rope pixel coincident with startOfFrame
    pixels(300, 10, 10, 1'b1, 1'b0, 1'b0);
    chk("sat_ropeCnt", dut.ropeCnt, 8'd255);
    monkeyDR = 1'b1; ropeDR = 1'b1; monkeyOffsetX = 11'd10; monkeyOffsetY = 11'd10;
    sofPulse();
    clearIn();
    chk("sat_onRope", {7'd0, onRope}, 8'd1);
    chk("sat_objectHit", {7'd0, objectHit}, 8'd0);
    chk("carry_ropeCnt", dut.ropeCnt, 8'd1);
    pixels(5, 10, 10, 1'b1, 1'b0, 1'b0);
    // Enemy pixel coincident with startOfFrame belongs to the next frame
    monkeyDR = 1'b1; enemyDR = 1'b1; monkeyOffsetX = 11'd10; monkeyOffsetY = 11'd10;
    sofPulse();
    clearIn();
    chk("carry_onRope", {7'd0, onRope}, 8'd1);
    chk("sofEnemy_excluded", {7'd0, objectHit}, 8'd0);
    sofPulse();
    chk("sofEnemy_next", {7'd0, objectHit}, 8'd1);
    chk("sofEnemy_pulse", {7'd0, hitPulse}, 8'd1);
    chk("sofEnemy_onRope", {7'd0, onRope}, 8'd0);

    // Mid-frame reset with enemy hits pending
    pixels(3, 10, 10, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_objectHit", {7'd0, objectHit}, 8'd0);
    chk("midrst_frameValid", {7'd0, frameValid}, 8'd0);
    pixels(2, 10, 10, 1'b0, 1'b0, 1'b1);
    sofPulse();
    chk("midrst_sof1_objectHit", {7'd0, objectHit}, 8'd0);
    chk("midrst_sof1_frameValid", {7'd0, frameValid}, 8'd0);
    pixels(2, 10, 10, 1'b0, 1'b0, 1'b1);
    sofPulse();
    chk("midrst_sof2_frameValid", {7'd0, frameValid}, 8'd1);
    chk("midrst_sof2_objectHit", {7'd0, objectHit}, 8'd1);
    chk("midrst_sof2_hitPulse", {7'd0, hitPulse}, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
